// File: rtl/ozdefs_pkg.sv
// ----------------------------------------------------------------------------
// ozdefs : shared definitions for the training ordered-set receiver.
//   - 8b symbol constants used by the TS1/TS2 parser and idle counter
//   - ts_os_t        : ordered-set type reported to the LTSSM
//   - ts_rx_state_t  : receiver FSM states
// ----------------------------------------------------------------------------
package ozdefs;

    localparam logic [7:0] COM   = 8'hBC;  // K28.5
    localparam logic [7:0] PAD   = 8'hF7;  // K23.7
    localparam logic [7:0] D10_2 = 8'h4A;  // TS1 identifier
    localparam logic [7:0] D5_2  = 8'h45;  // TS2 identifier
    localparam logic [7:0] IDL   = 8'h00;  // logical idle data

    typedef enum logic [1:0] {
        OS_NONE = 2'd0,
        OS_TS1  = 2'd1,
        OS_TS2  = 2'd2
    } ts_os_t;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        BODY = 2'd1,
        DONE = 2'd2
    } ts_rx_state_t;

endpackage

// File: rtl/ts_field_capture.sv
// ----------------------------------------------------------------------------
// ts_field_capture : 15-byte capture register for the symbols following COM,
// plus (when OZ_TS_CONSEC_CHECK_EN is defined) the previous committed set's
// symbols 1-5 and a compare against the set currently held.
//
// Ports:
//   clk, reset          symbol clock, async active-high reset
//   wr_en/wr_idx        write strobe and symbol index (1..15)
//   wr_data/wr_k        symbol byte and its K flag
//   link_byte/lane_byte symbols 1 and 2 as captured
//   link_is_d/lane_is_d symbols 1 and 2 were captured as D symbols
//   ctrl_byte           symbol 5 (training control)
//   ids_match           symbols 7..15 all equal symbol 6
//   commit, prev_clr    (macro only) latch / forget the previous set
//   set_differs         (macro only) symbols 1-5 differ from the previous set
// ----------------------------------------------------------------------------
module ts_field_capture
    import ozdefs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic       wr_k,
    output logic [7:0] link_byte,
    output logic [7:0] lane_byte,
    output logic       link_is_d,
    output logic       lane_is_d,
    output logic [7:0] ctrl_byte,
    output logic       ids_match
`ifdef OZ_TS_CONSEC_CHECK_EN
    ,
    input  logic       commit,
    input  logic       prev_clr,
    output logic       set_differs
`endif
);

    logic [7:0] cap_r [1:15];
    logic       link_k_r;
    logic       lane_k_r;

    // Capture each body symbol at its index; K flags kept for symbols 1 and 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= 15; i++) begin
                cap_r[i] <= 8'h00;
            end
            link_k_r <= 1'b0;
            lane_k_r <= 1'b0;
        end else if (wr_en) begin
            for (int i = 1; i <= 15; i++) begin
                if (wr_idx == 4'(i)) begin
                    cap_r[i] <= wr_data;
                end
            end
            if (wr_idx == 4'd1) begin
                link_k_r <= wr_k;
            end
            if (wr_idx == 4'd2) begin
                lane_k_r <= wr_k;
            end
        end
    end

    assign link_byte = cap_r[1];
    assign lane_byte = cap_r[2];
    assign link_is_d = ~link_k_r;
    assign lane_is_d = ~lane_k_r;
    assign ctrl_byte = cap_r[5];

    // Second look at the identifier run before a set is allowed to commit.
    always_comb begin
        ids_match = 1'b1;
        for (int i = 7; i <= 15; i++) begin
            if (cap_r[i] != cap_r[6]) begin
                ids_match = 1'b0;
            end else begin
                ids_match = ids_match;
            end
        end
    end

`ifdef OZ_TS_CONSEC_CHECK_EN
    logic [7:0] prev_r [1:5];
    logic       prev_link_k_r;
    logic       prev_lane_k_r;
    logic       prev_valid_r;

    // Remember symbols 1-5 of the last committed set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= 5; i++) begin
                prev_r[i] <= 8'h00;
            end
            prev_link_k_r <= 1'b0;
            prev_lane_k_r <= 1'b0;
            prev_valid_r  <= 1'b0;
        end else if (prev_clr) begin
            prev_valid_r <= 1'b0;
        end else if (commit) begin
            for (int i = 1; i <= 5; i++) begin
                prev_r[i] <= cap_r[i];
            end
            prev_link_k_r <= link_k_r;
            prev_lane_k_r <= lane_k_r;
            prev_valid_r  <= 1'b1;
        end
    end

    // With no remembered set, any set counts as different.
    always_comb begin
        set_differs = ~prev_valid_r;
        if ((prev_link_k_r != link_k_r) || (prev_lane_k_r != lane_k_r)) begin
            set_differs = 1'b1;
        end else begin
            set_differs = set_differs;
        end
        for (int i = 1; i <= 5; i++) begin
            if (prev_r[i] != cap_r[i]) begin
                set_differs = 1'b1;
            end else begin
                set_differs = set_differs;
            end
        end
    end
`endif

endmodule

// File: rtl/ts_os_rcvr.sv
// ----------------------------------------------------------------------------
// ts_os_rcvr : per-lane TS1/TS2 ordered-set receiver feeding the LTSSM.
// Parses COM + 15 body symbols, publishes TS counters, link/lane numbers,
// training control, last ordered-set type and a logical-idle counter.
//
// Build option: OZ_TS_CONSEC_CHECK_EN -- when defined the TS counters count
// consecutive identical sets; otherwise they are cumulative.
//
// Ports:
//   clk, reset                 symbol clock, async active-high reset
//   rxdata/rxdatak/rxvalid     PHY symbol stream
//   ctr_clr                    sync clear of TS counters and captured fields
//   idle_en                    enables logical-idle counting
//   os_done                    one-cycle pulse per committed TS1/TS2
//   os_type                    type of the last committed set
//   ts1_ctr/ts2_ctr            TS counters (saturating)
//   link_num/lane_num          symbols 1/2 of the last committed set
//   link_proposed/lane_proposed  those symbols were not PAD
//   train_ctrl                 symbol 5 of the last committed set
//   idle_ctr                   consecutive idle-data count (saturating)
// ----------------------------------------------------------------------------
module ts_os_rcvr
    import ozdefs::*;
#(
    parameter int CTR_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rxdata,
    input  logic             rxdatak,
    input  logic             rxvalid,
    input  logic             ctr_clr,
    input  logic             idle_en,
    output logic             os_done,
    output ts_os_t           os_type,
    output logic [CTR_W-1:0] ts1_ctr,
    output logic [CTR_W-1:0] ts2_ctr,
    output logic [7:0]       link_num,
    output logic [7:0]       lane_num,
    output logic             link_proposed,
    output logic             lane_proposed,
    output logic [7:0]       train_ctrl,
    output logic [CTR_W-1:0] idle_ctr
);

    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
        return (v == CTR_MAX) ? v : v + CTR_ONE;
    endfunction

    ts_rx_state_t state_r;
    logic [3:0]   idx_r;
    logic         is_ts2_r;

    logic         is_com_s;
    logic         sym_legal_s;
    logic         abort_s;
    logic         commit_s;
    logic         wr_en_s;
    logic [7:0]   link_byte_s;
    logic [7:0]   lane_byte_s;
    logic         link_is_d_s;
    logic         lane_is_d_s;
    logic [7:0]   ctrl_byte_s;
    logic         ids_match_s;
`ifdef OZ_TS_CONSEC_CHECK_EN
    logic         set_differs_s;
`endif

    assign is_com_s = rxvalid && rxdatak && (rxdata == COM);

    // Legality of the current body symbol at idx_r (COM handled separately).
    always_comb begin
        sym_legal_s = 1'b0;
        if (rxdatak) begin
            sym_legal_s = (idx_r <= 4'd2) && (rxdata == PAD);
        end else if (idx_r == 4'd6) begin
            sym_legal_s = (rxdata == D10_2) || (rxdata == D5_2);
        end else if (idx_r >= 4'd7) begin
            sym_legal_s = (rxdata == (is_ts2_r ? D5_2 : D10_2));
        end else begin
            sym_legal_s = 1'b1;
        end
    end

    assign abort_s  = (state_r == BODY) && (!rxvalid || (!is_com_s && !sym_legal_s));
    assign commit_s = (state_r == DONE) && ids_match_s;
    assign wr_en_s  = (state_r == BODY) && rxvalid && !is_com_s;

    ts_field_capture u_cap (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en_s),
        .wr_idx     (idx_r),
        .wr_data    (rxdata),
        .wr_k       (rxdatak),
        .link_byte  (link_byte_s),
        .lane_byte  (lane_byte_s),
        .link_is_d  (link_is_d_s),
        .lane_is_d  (lane_is_d_s),
        .ctrl_byte  (ctrl_byte_s),
        .ids_match  (ids_match_s)
`ifdef OZ_TS_CONSEC_CHECK_EN
        ,
        .commit     (commit_s && !ctr_clr),
        .prev_clr   (ctr_clr),
        .set_differs(set_differs_s)
`endif
    );

    // Parser FSM together with the registered TS outputs it commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= HUNT;
            idx_r         <= 4'd0;
            is_ts2_r      <= 1'b0;
            os_done       <= 1'b0;
            os_type       <= OS_NONE;
            ts1_ctr       <= CTR_ZERO;
            ts2_ctr       <= CTR_ZERO;
            link_num      <= PAD;
            lane_num      <= PAD;
            link_proposed <= 1'b0;
            lane_proposed <= 1'b0;
            train_ctrl    <= 8'h00;
        end else begin
            os_done <= 1'b0;

            case (state_r)
                HUNT: begin
                    if (is_com_s) begin
                        state_r <= BODY;
                        idx_r   <= 4'd1;
                    end
                end
                BODY: begin
                    if (abort_s) begin
                        state_r <= HUNT;
                    end else if (is_com_s) begin
                        idx_r <= 4'd1;  // restart, not an abort
                    end else begin
                        if (idx_r == 4'd6) begin
                            is_ts2_r <= (rxdata == D5_2);
                        end
                        if (idx_r == 4'd15) begin
                            state_r <= DONE;
                        end else begin
                            idx_r <= idx_r + 4'd1;
                        end
                    end
                end
                DONE: begin
                    // Next set's COM may arrive in the commit cycle.
                    if (is_com_s) begin
                        state_r <= BODY;
                        idx_r   <= 4'd1;
                    end else begin
                        state_r <= HUNT;
                    end
                end
                default: begin
                    state_r <= HUNT;
                end
            endcase

            if (ctr_clr) begin
                os_type       <= OS_NONE;
                ts1_ctr       <= CTR_ZERO;
                ts2_ctr       <= CTR_ZERO;
                link_num      <= PAD;
                lane_num      <= PAD;
                link_proposed <= 1'b0;
                lane_proposed <= 1'b0;
                train_ctrl    <= 8'h00;
            end else if (commit_s) begin
                os_done       <= 1'b1;
                os_type       <= is_ts2_r ? OS_TS2 : OS_TS1;
                link_num      <= link_byte_s;
                lane_num      <= lane_byte_s;
                link_proposed <= (link_byte_s != PAD) || link_is_d_s;
                lane_proposed <= (lane_byte_s != PAD) || lane_is_d_s;
                train_ctrl    <= ctrl_byte_s;
`ifdef OZ_TS_CONSEC_CHECK_EN
                if (is_ts2_r) begin
                    ts2_ctr <= set_differs_s ? CTR_ONE : sat_inc(ts2_ctr);
                    ts1_ctr <= CTR_ZERO;
                end else begin
                    ts1_ctr <= set_differs_s ? CTR_ONE : sat_inc(ts1_ctr);
                    ts2_ctr <= CTR_ZERO;
                end
            end else if (abort_s) begin
                ts1_ctr <= CTR_ZERO;
                ts2_ctr <= CTR_ZERO;
`else
                if (is_ts2_r) begin
                    ts2_ctr <= sat_inc(ts2_ctr);
                end else begin
                    ts1_ctr <= sat_inc(ts1_ctr);
                end
`endif
            end
        end
    end

    // Logical-idle counter: counts consecutive idle data symbols, holds on gaps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_ctr <= CTR_ZERO;
        end else if (!idle_en) begin
            idle_ctr <= CTR_ZERO;
        end else if (rxvalid) begin
            if (!rxdatak && (rxdata == IDL)) begin
                idle_ctr <= sat_inc(idle_ctr);
            end else begin
                idle_ctr <= CTR_ZERO;
            end
        end
    end

endmodule

// File: tb/tb_ts_os_rcvr.sv
module tb_ts_os_rcvr;

`ifdef OZ_TS_CONSEC_CHECK_EN
    localparam bit CONSEC = 1'b1;
`else
    localparam bit CONSEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rxdata;
    logic        rxdatak;
    logic        rxvalid;
    logic        ctr_clr;
    logic        idle_en;
    logic        os_done;
    logic [1:0]  os_type;
    logic [15:0] ts1_ctr;
    logic [15:0] ts2_ctr;
    logic [7:0]  link_num;
    logic [7:0]  lane_num;
    logic        link_proposed;
    logic        lane_proposed;
    logic [7:0]  train_ctrl;
    logic [15:0] idle_ctr;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    ts_os_rcvr #(.CTR_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rxdata       (rxdata),
        .rxdatak      (rxdatak),
        .rxvalid      (rxvalid),
        .ctr_clr      (ctr_clr),
        .idle_en      (idle_en),
        .os_done      (os_done),
        .os_type      (os_type),
        .ts1_ctr      (ts1_ctr),
        .ts2_ctr      (ts2_ctr),
        .link_num     (link_num),
        .lane_num     (lane_num),
        .link_proposed(link_proposed),
        .lane_proposed(lane_proposed),
        .train_ctrl   (train_ctrl),
        .idle_ctr     (idle_ctr)
    );

    always #5 clk = ~clk;

    // Count os_done pulses shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (os_done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_sym(input logic [7:0] d, input logic k);
        @(negedge clk);
        rxdata  = d;
        rxdatak = k;
        rxvalid = 1'b1;
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            rxdata  = 8'h00;
            rxdatak = 1'b0;
            rxvalid = 1'b0;
        end
    endtask

    // COM + symbols 1..len-1 of a TS; symbol bad_idx (if nonzero) replaced by bad_val.
    task automatic send_ts(input logic [7:0] id, input logic [7:0] lnk, input logic lk,
                           input logic [7:0] lan, input logic nk, input logic [7:0] s5,
                           input int len, input int bad_idx, input logic [7:0] bad_val);
        logic [7:0] sym;
        logic       kk;
        for (int i = 0; i < len; i++) begin
            kk = 1'b0;
            case (i)
                0: begin sym = 8'hBC; kk = 1'b1; end
                1: begin sym = lnk; kk = lk; end
                2: begin sym = lan; kk = nk; end
                3: sym = 8'h10;
                4: sym = 8'h02;
                5: sym = s5;
                default: sym = id;
            endcase
            if (bad_idx != 0 && i == bad_idx) sym = bad_val;
            send_sym(sym, kk);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        ctr_clr = 1'b1;
        rxvalid = 1'b0;
        @(negedge clk);
        ctr_clr = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        rxdata  = 8'h00;
        rxdatak = 1'b0;
        rxvalid = 1'b0;
        ctr_clr = 1'b0;
        idle_en = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_os_done", 32'(os_done), 32'h0);
        chk("rst_os_type", 32'(os_type), 32'h0);
        chk("rst_ts1", 32'(ts1_ctr), 32'h0);
        chk("rst_ts2", 32'(ts2_ctr), 32'h0);
        chk("rst_link", 32'(link_num), 32'hF7);
        chk("rst_lane", 32'(lane_num), 32'hF7);
        chk("rst_link_prop", 32'(link_proposed), 32'h0);
        chk("rst_train", 32'(train_ctrl), 32'h0);
        chk("rst_idle", 32'(idle_ctr), 32'h0);
        reset = 1'b0;

        // 16 back-to-back TS1 with PAD link/lane
        repeat (16) send_ts(8'h4A, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h00, 16, 0, 8'h00);
        idle_cyc(2);
        chk("b2b_ts1", 32'(ts1_ctr), 32'd16);
        chk("b2b_ts2", 32'(ts2_ctr), 32'd0);
        chk("b2b_type", 32'(os_type), 32'd1);
        chk("b2b_link_prop", 32'(link_proposed), 32'h0);
        chk("b2b_lane_prop", 32'(lane_proposed), 32'h0);
        chk("b2b_link", 32'(link_num), 32'hF7);
        chk("b2b_done", 32'(done_cnt), 32'd16);

        // Clear, then 8 TS1 + 8 TS2 with link 5 lane 2
        pulse_clr();
        chk("clr_ts1", 32'(ts1_ctr), 32'd0);
        chk("clr_type", 32'(os_type), 32'd0);
        chk("clr_link", 32'(link_num), 32'hF7);
        repeat (8) send_ts(8'h4A, 8'h05, 1'b0, 8'h02, 1'b0, 8'h00, 16, 0, 8'h00);
        repeat (8) send_ts(8'h45, 8'h05, 1'b0, 8'h02, 1'b0, 8'h01, 16, 0, 8'h00);
        idle_cyc(2);
        chk("mix_link", 32'(link_num), 32'h05);
        chk("mix_lane", 32'(lane_num), 32'h02);
        chk("mix_link_prop", 32'(link_proposed), 32'h1);
        chk("mix_lane_prop", 32'(lane_proposed), 32'h1);
        chk("mix_train", 32'(train_ctrl), 32'h01);
        chk("mix_type", 32'(os_type), 32'd2);
        chk("mix_ts1", 32'(ts1_ctr), CONSEC ? 32'd0 : 32'd8);
        chk("mix_ts2", 32'(ts2_ctr), 32'd8);
        chk("mix_done", 32'(done_cnt), 32'd32);

        // Bad identifier at symbol 10 aborts the set
        send_ts(8'h4A, 8'h05, 1'b0, 8'h02, 1'b0, 8'h00, 16, 10, 8'h45);
        idle_cyc(2);
        chk("abort_done", 32'(done_cnt), 32'd32);
        chk("abort_ts1", 32'(ts1_ctr), CONSEC ? 32'd0 : 32'd8);
        chk("abort_ts2", 32'(ts2_ctr), CONSEC ? 32'd0 : 32'd8);
        chk("abort_type", 32'(os_type), 32'd2);

        // COM at idx 9 restarts; following TS2 completes once
        send_ts(8'h4A, 8'h05, 1'b0, 8'h02, 1'b0, 8'h00, 9, 0, 8'h00);
        send_ts(8'h45, 8'h05, 1'b0, 8'h02, 1'b0, 8'h01, 16, 0, 8'h00);
        idle_cyc(2);
        chk("restart_done", 32'(done_cnt), 32'd33);
        chk("restart_type", 32'(os_type), 32'd2);
        chk("restart_ts2", 32'(ts2_ctr), CONSEC ? 32'd1 : 32'd9);
        chk("restart_ts1", 32'(ts1_ctr), CONSEC ? 32'd0 : 32'd8);

        // ctr_clr in the commit cycle wins
        send_ts(8'h4A, 8'h07, 1'b0, 8'h03, 1'b0, 8'h00, 16, 0, 8'h00);
        @(negedge clk);
        ctr_clr = 1'b1;
        rxvalid = 1'b0;
        @(negedge clk);
        ctr_clr = 1'b0;
        chk("clrwin_done", 32'(done_cnt), 32'd33);
        chk("clrwin_os_done", 32'(os_done), 32'h0);
        chk("clrwin_ts1", 32'(ts1_ctr), 32'd0);
        chk("clrwin_ts2", 32'(ts2_ctr), 32'd0);
        chk("clrwin_link", 32'(link_num), 32'hF7);
        chk("clrwin_type", 32'(os_type), 32'd0);
        send_ts(8'h45, 8'h09, 1'b0, 8'hF7, 1'b1, 8'h04, 16, 0, 8'h00);
        idle_cyc(2);
        chk("after_clr_ts2", 32'(ts2_ctr), 32'd1);
        chk("after_clr_link", 32'(link_num), 32'h09);
        chk("after_clr_lane_prop", 32'(lane_proposed), 32'h0);
        chk("after_clr_done", 32'(done_cnt), 32'd34);

        // Logical idle counting with a gap
        idle_en = 1'b1;
        repeat (10) send_sym(8'h00, 1'b0);
        idle_cyc(1);
        chk("idle_10", 32'(idle_ctr), 32'd10);
        idle_cyc(2);
        chk("idle_hold", 32'(idle_ctr), 32'd10);
        repeat (10) send_sym(8'h00, 1'b0);
        send_sym(8'hBC, 1'b1);
        chk("idle_20", 32'(idle_ctr), 32'd20);
        idle_cyc(1);
        chk("idle_clr_k", 32'(idle_ctr), 32'd0);
        repeat (3) send_sym(8'h00, 1'b0);
        @(negedge clk);
        rxvalid = 1'b0;
        idle_en = 1'b0;
        chk("idle_3", 32'(idle_ctr), 32'd3);
        @(negedge clk);
        chk("idle_dis", 32'(idle_ctr), 32'd0);

        // Reset mid-set
        send_ts(8'h4A, 8'h05, 1'b0, 8'h02, 1'b0, 8'h00, 6, 0, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ts2", 32'(ts2_ctr), 32'd0);
        chk("mid_rst_link", 32'(link_num), 32'hF7);
        chk("mid_rst_type", 32'(os_type), 32'd0);
        chk("mid_rst_train", 32'(train_ctrl), 32'h0);
        @(negedge clk);
        reset   = 1'b0;
        rxvalid = 1'b0;
        repeat (10) send_sym(8'h4A, 1'b0);
        idle_cyc(2);
        chk("mid_rst_no_done", 32'(done_cnt), 32'd34);
        chk("mid_rst_ts1", 32'(ts1_ctr), 32'd0);
        send_ts(8'h4A, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 16, 0, 8'h00);
        idle_cyc(2);
        chk("post_rst_ts1", 32'(ts1_ctr), 32'd1);
        chk("post_rst_done", 32'(done_cnt), 32'd35);
        chk("post_rst_lane", 32'(lane_num), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
